vector_mac: RTL

VECTOR_MAC -- requirements
Module: vector_mac

---
 rtl/vector_mac_if.sv | 32 +++
 rtl/vector_mac.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mac_if.sv
// Operand/result handshake bundle for vector_mac: two independent operand
// channels (a with its mode bit, b) and one result channel carrying result, dot and error.
interface vector_mac_if #(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int DOT_WIDTH         = 16
);
  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a;
  logic                                    a_valid;
  logic                                    a_ready;
  logic                                    mode;
  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b;
  logic                                    b_valid;
  logic                                    b_ready;
  logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result;
  logic [DOT_WIDTH-1:0]                    dot;
  logic                                    result_valid;
  logic                                    result_ready;
  logic                                    error;

  modport master (
    output a, a_valid, mode, b, b_valid, result_ready,
    input  a_ready, b_ready, result, dot, result_valid, error
  );

  modport slave (
    input  a, a_valid, mode, b, b_valid, result_ready,
    output a_ready, b_ready, result, dot, result_valid, error
  );
endinterface

// File: rtl/vector_mac.sv
// Tiled signed fixed-point vector multiplier: elementwise products (mode 0) or dot product (mode 1).
// Define VECTOR_MAC_SATURATE_EN to clamp out-of-range values instead of truncating them.
module vector_mac #(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int DOT_WIDTH         = 16,
  parameter int FRACTION_WIDTH    = 4,
  parameter int TILING            = 1
) (
  input  logic        clk,
  input  logic        rst,
  vector_mac_if.slave bus
);
  localparam int PROD_W   = A_CELL_WIDTH + B_CELL_WIDTH;
  localparam int ACC_W    = PROD_W + $clog2(VECTOR_LEN) + 1;
  localparam int WIDE_TGT = (DOT_WIDTH > RESULT_CELL_WIDTH) ? DOT_WIDTH : RESULT_CELL_WIDTH;
  localparam int EXT_W    = ((ACC_W > WIDE_TGT) ? ACC_W : WIDE_TGT) + 1;
  localparam int IDX_W    = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam int CNT_W    = $clog2(VECTOR_LEN + TILING + 1);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(TILING);
  localparam logic [CNT_W-1:0] VLEN = CNT_W'(VECTOR_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [VECTOR_LEN*A_CELL_WIDTH-1:0] a_reg;
  logic [VECTOR_LEN*B_CELL_WIDTH-1:0] b_reg;
  logic                               mode_reg;
  logic                               a_set_reg;
  logic                               b_set_reg;
  logic [CNT_W-1:0]                   counter_reg;
  logic signed [ACC_W-1:0]            acc_reg;
  logic [RESULT_CELL_WIDTH-1:0]       result_reg [VECTOR_LEN];
  logic [DOT_WIDTH-1:0]               dot_reg;
  logic                               error_reg;

  logic a_fire;
  logic b_fire;
  logic calc_last;
  logic done_ack;
  logic result_valid_next;

  logic signed [A_CELL_WIDTH-1:0]      a_cell   [VECTOR_LEN];
  logic signed [B_CELL_WIDTH-1:0]      b_cell   [VECTOR_LEN];
  logic [CNT_W-1:0]                    lane_idx [TILING];
  logic signed [EXT_W-1:0]             lane_prod [TILING];
  logic [RESULT_CELL_WIDTH-1:0]        lane_cell [TILING];
  logic [TILING-1:0]                   lane_active;
  logic [TILING-1:0]                   lane_ovf;
  logic signed [ACC_W-1:0]             lane_sum;
  logic                                lane_err;
  logic signed [ACC_W-1:0]             acc_sum;
  logic signed [EXT_W-1:0]             dot_wide;
  logic                                dot_ovf;

  // Returns v clamped (or passed through for later truncation) and flags
  // whether v lies outside the signed range of a w-bit target.
  function automatic logic signed [EXT_W-1:0] reduce(
    input  logic signed [EXT_W-1:0] v,
    input  int                      w,
    output logic                    ovf
  );
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    hi  = (EXT_W'(1) <<< (w - 1)) - EXT_W'(1);
    lo  = ~hi;
    ovf = (v > hi) || (v < lo);
`ifdef VECTOR_MAC_SATURATE_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return v;
`endif
  endfunction

  genvar gi;

  generate
    for (gi = 0; gi < VECTOR_LEN; gi++) begin : g_cells
      assign a_cell[gi] = a_reg[gi*A_CELL_WIDTH +: A_CELL_WIDTH];
      assign b_cell[gi] = b_reg[gi*B_CELL_WIDTH +: B_CELL_WIDTH];
      assign bus.result[gi*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = result_reg[gi];
    end
  endgenerate

  // Each lane handles cell counter+gi; lanes past the end of the vector yield zero.
  generate
    for (gi = 0; gi < TILING; gi++) begin : g_lanes
      logic [IDX_W-1:0]         sel;
      logic signed [PROD_W-1:0] mul;
      logic signed [EXT_W-1:0]  red;
      logic                     ovf;

      assign lane_idx[gi]    = counter_reg + CNT_W'(gi);
      assign lane_active[gi] = lane_idx[gi] < VLEN;
      assign sel             = lane_idx[gi][IDX_W-1:0];
      assign mul             = PROD_W'(a_cell[sel]) * PROD_W'(b_cell[sel]);
      assign lane_prod[gi]   = lane_active[gi] ? EXT_W'(mul >>> FRACTION_WIDTH) : {EXT_W{1'b0}};

      always_comb begin
        ovf = 1'b0;
        red = reduce(lane_prod[gi], RESULT_CELL_WIDTH, ovf);
      end

      assign lane_cell[gi] = RESULT_CELL_WIDTH'(red);
      assign lane_ovf[gi]  = ovf;
    end
  endgenerate

  always_comb begin
    lane_sum = '0;
    lane_err = 1'b0;
    for (int li = 0; li < TILING; li++) begin
      lane_sum = lane_sum + ACC_W'(lane_prod[li]);
      lane_err = lane_err | lane_ovf[li];
    end
  end

  assign acc_sum = acc_reg + lane_sum;

  always_comb begin
    dot_ovf  = 1'b0;
    dot_wide = reduce(EXT_W'(acc_sum), DOT_WIDTH, dot_ovf);
  end

  assign a_fire = bus.a_valid && !a_set_reg;
  assign b_fire = bus.b_valid && !b_set_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    calc_last         = 1'b0;
    done_ack          = 1'b0;
    result_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (a_set_reg && b_set_reg) state_next = CALC;
      end
      CALC: begin
        calc_last = (counter_reg + STEP) >= VLEN;
        if (calc_last) state_next = DONE;
      end
      DONE: begin
        result_valid_next = 1'b1;
        done_ack          = bus.result_ready;
        if (done_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      mode_reg    <= 1'b0;
      a_set_reg   <= 1'b0;
      b_set_reg   <= 1'b0;
      counter_reg <= '0;
      acc_reg     <= '0;
      dot_reg     <= '0;
      error_reg   <= 1'b0;
      for (int ci = 0; ci < VECTOR_LEN; ci++) result_reg[ci] <= '0;
    end else begin
      if (a_fire) begin
        a_reg     <= bus.a;
        mode_reg  <= bus.mode;
        a_set_reg <= 1'b1;
      end
      if (b_fire) begin
        b_reg     <= bus.b;
        b_set_reg <= 1'b1;
      end

      if (state_reg == CALC) begin
        counter_reg <= calc_last ? '0 : counter_reg + STEP;
        if (mode_reg) begin
          acc_reg <= acc_sum;
          if (calc_last) begin
            dot_reg <= DOT_WIDTH'(dot_wide);
            if (dot_ovf) error_reg <= 1'b1;
          end
        end else begin
          for (int li = 0; li < TILING; li++) begin
            if (lane_active[li]) result_reg[lane_idx[li][IDX_W-1:0]] <= lane_cell[li];
          end
          if (lane_err) error_reg <= 1'b1;
        end
      end

      // Handshake in DONE releases both operand slots and wipes the outputs.
      if (done_ack) begin
        a_set_reg <= 1'b0;
        b_set_reg <= 1'b0;
        acc_reg   <= '0;
        dot_reg   <= '0;
        error_reg <= 1'b0;
        for (int ci = 0; ci < VECTOR_LEN; ci++) result_reg[ci] <= '0;
      end
    end
  end

  assign bus.a_ready      = !a_set_reg;
  assign bus.b_ready      = !b_set_reg;
  assign bus.result_valid = result_valid_next;
  assign bus.dot          = dot_reg;
  assign bus.error        = error_reg;
endmodule
